// File: rtl/fetch_ctrl_if.sv
// Fetch-path bus bundle: instruction-memory read port plus the
// valid/ready instruction handshake toward decode.
interface fetch_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;

  // Fetch controller side
  modport master (
    output mem_addr,
    input  mem_data,
    output instr_valid,
    input  instr_ready,
    output instr_out,
    output instr_pc
  );

  // Memory / decode side
  modport slave (
    input  mem_addr,
    output mem_data,
    input  instr_valid,
    output instr_ready,
    input  instr_out,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a 1-cycle-latency
// synchronous memory, and holds each fetched word for decode until it is
// accepted. Redirect reloads the PC and drops anything in flight.
module fetch_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  fetch_ctrl_if.master      bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

  // State and datapath registers; reset is asynchronous so it also aborts a fetch mid-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= ADDR_W'(RESET_PC);
      instr_valid_q <= 1'b0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  // Next-state logic: redirect overrides capture/increment; otherwise walk
  // FETCH -> CAPTURE -> HOLD and wait in HOLD for the decode handshake.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;

    if (redirect_valid) begin
      // A handshake in the same HOLD cycle still counts; dropping valid
      // here is what prevents the word from being presented twice.
      pc_d          = redirect_addr;
      instr_valid_d = 1'b0;
      state_d       = run ? S_FETCH : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run) state_d = S_FETCH;
        end
        S_FETCH: begin
          // Memory samples pc on this edge; data shows up next cycle.
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          instr_out_d   = bus.mem_data;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + ADDR_W'(1);  // wraps naturally
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = run ? S_FETCH : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_pc    = instr_pc_q;
  assign pc              = pc_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch path: owns the program counter, drives the address of the synchronous 256x16 instruction memory (1-cycle read latency), and captures each returned word into an output instruction register. It presents instructions to decode over a valid/ready handshake. It supports stall via back-pressure, run/stop control and branch redirect with flush. It sits between the instruction memory and the decode stage.

Parameters:
ADDR_W, 8, PC / memory address width
INSTR_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
run  in  1  1 = fetch continuously; 0 = finish current instruction, then idle
redirect_valid  in  1  branch/jump: load new PC and flush
redirect_addr  in  ADDR_W  redirect target
mem_addr  out  ADDR_W  address to instruction memory (combinational = pc)
mem_data  in  INSTR_W  memory read data, valid the cycle after address sampled
instr_valid  out  1  instr_out/instr_pc hold a valid instruction
instr_ready  in  1  decode accepts instruction this cycle
instr_out  out  INSTR_W  captured instruction word
instr_pc  out  ADDR_W  address the instruction was fetched from
pc  out  ADDR_W  current fetch PC
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (async, immediate, also mid-fetch): state=IDLE, pc=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, busy=0.
- mem_addr = pc at all times; memory samples it each edge.
- States:
  - IDLE: instr_valid=0. If run=1, go to FETCH next edge.
  - FETCH: address pc is presented; memory samples it on this edge. Go to CAPTURE.
  - CAPTURE: mem_data is valid. On the edge: instr_out<=mem_data, instr_pc<=pc, pc<=pc+1, instr_valid<=1. Go to HOLD.
  - HOLD: instr_valid=1, outputs stable.
    - If instr_ready=1 (handshake): instr_valid<=0. Go to FETCH if run=1, else IDLE.
    - If instr_ready=0: stay in HOLD, all outputs unchanged.
- Latency: run rises -> first instr_valid 3 edges later.
- Throughput: 1 instruction per 3 cycles with instr_ready held high.
- PC arithmetic: pc+1 modulo 2^ADDR_W. 0xFF wraps to 0x00, no flag.
- run=0 during FETCH/CAPTURE: the fetch completes and its instruction is delivered. IDLE is entered only after the HOLD handshake.
- Redirect (redirect_valid=1, any non-reset state):
  - Next edge: pc<=redirect_addr, instr_valid<=0.
  - Any in-flight memory data is discarded.
  - Next state: FETCH if run=1, else IDLE.
  - Redirect takes priority over capture and pc increment.
- Redirect in HOLD with instr_ready=1 in the same cycle: the handshake counts as accepted, the redirect still applies, and no duplicate instruction is delivered.
- Redirect in IDLE with run=0: pc is loaded; the block stays IDLE.
- Priority: reset > redirect > handshake/normal sequencing.
- instr_out/instr_pc change only on a CAPTURE edge or reset.

Test Plan:
1. Reset, memory[0..3]=1111,2222,3333,4444, run=1, ready=1 -> instr_out 1111@pc0, 2222@pc1, 3333@pc2 at valid edges 3, 6, 9 cycles after run; busy=1.
2. Stall: hold ready=0 for 5 cycles after first valid -> instr_valid stays 1, instr_out=1111, instr_pc=0, pc=1, mem_addr=1 throughout; releasing ready delivers 2222 next.
3. Redirect to 0x80 while in CAPTURE fetching pc=2 -> word at 2 never valid; next delivered instruction has instr_pc=0x80, instr_out=memory[0x80]; pc=0x81 afterwards.
4. Wrap: redirect to 0xFF, run=1 -> deliver memory[0xFF] with instr_pc=0xFF, then memory[0x00] with instr_pc=0x00.
5. run dropped during FETCH of pc=5 -> instruction at 5 still delivered; after the handshake state=IDLE, busy=0, pc=6, no further instr_valid.
6. Assert reset asynchronously mid-HOLD (between edges) -> instr_valid, busy, instr_out drop to 0 immediately; pc=RESET_PC; after release with run=1 fetching restarts at pc 0.
